link_upstream_nch: RTL and testbench
====================================

LINK_UPSTREAM_NCH -- requirements
Module: link_upstream_nch

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of outbound lanes.
REQ-002 SHALL have parameter CH_WIDTH, default 8, data bits per lane per phase.
REQ-003 SHALL have parameter CREDITS, default 16, maximum outstanding words per lane.
REQ-004 SHALL have parameter TOKEN_DECIM, default 8, credits returned per token edge; TOKEN_DECIM <= CREDITS.
REQ-005 SHALL define localparams CORE_W = 2*CHANNELS*CH_WIDTH and CRW = clog2(CREDITS+1).
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port core_valid_i, input, 1, core word valid.
REQ-009 SHALL have port core_data_i, input, CORE_W, core word.
REQ-010 SHALL have port core_ready_o, output, 1, word accepted this cycle when high with core_valid_i.
REQ-011 SHALL have port io_valid_o, output, CHANNELS, per-lane valid.
REQ-012 SHALL have port io_data_o, output, CHANNELS*CH_WIDTH, per-lane data; lane c at [c*CH_WIDTH +: CH_WIDTH].
REQ-013 SHALL have port io_token_i, input, CHANNELS, per-lane credit-return token level.
REQ-014 SHALL have port credits_o, output, CHANNELS*CRW, per-lane available credits.
REQ-015 SHALL have port sent_cnt_o, output, 8, words accepted, mod 256.
REQ-016 SHALL have port err_o, output, 1, sticky credit-overflow flag.

Function
REQ-017 SHALL implement FSM states IDLE, PH0, PH1; encoding free.
REQ-018 SHALL drive core_ready_o = (state IDLE or PH1) and every lane credit >= 1; combinational, no dependency on core_valid_i.
REQ-019 SHALL, on accept (core_valid_i & core_ready_o), latch core_data_i into a hold register and enter PH0 next cycle.
REQ-020 SHALL in PH0 drive io_valid_o all ones, lane c = hold[c*CH_WIDTH +: CH_WIDTH].
REQ-021 SHALL in PH1 drive io_valid_o all ones, lane c = hold[(CHANNELS+c)*CH_WIDTH +: CH_WIDTH].
REQ-022 SHALL go PH1 -> PH0 on accept in PH1 (back-to-back, no bubble), else PH1 -> IDLE; PH0 -> PH1 always.
REQ-023 SHALL in IDLE drive io_valid_o = 0 and io_data_o = 0.
REQ-024 SHALL register io_token_i per lane and detect rising edges (token_i & ~token_q); one edge = TOKEN_DECIM credits.
REQ-025 SHALL update each lane credit next cycle by -1 on accept and +TOKEN_DECIM on its token edge; both same cycle -> net +TOKEN_DECIM-1.
REQ-026 SHALL saturate a lane credit at CREDITS and set err_o when the unsaturated sum exceeds CREDITS; err_o clears only on rst.
REQ-027 SHALL never accept with any lane credit 0; credits therefore never underflow.
REQ-028 SHALL increment sent_cnt_o by 1 per accept, wrapping 255 -> 0.

Reset
REQ-029 SHALL on rst set state IDLE, hold 0, every credit CREDITS, token_q 0, sent_cnt_o 0, err_o 0 at the next edge.
REQ-030 SHALL give rst priority over accept and token edges in the same cycle; an in-flight word mid PH0/PH1 is dropped.
REQ-031 SHALL hold core_ready_o low while rst is asserted.

Verification
REQ-032 Defaults, after reset, accept core_data_i=32'h44332211 -> next cycle io_valid_o=2'b11, io_data_o=16'h2211; following cycle 16'h4433; credits 15/15; sent_cnt_o=1.
REQ-033 16 back-to-back accepts, no tokens -> continuous PH0/PH1, credits 0/0, core_ready_o low after 16th accept, IDLE after last PH1.
REQ-034 Credits 0/0, rising edge on io_token_i[0] only -> lane0 credit 8, ready stays low; then edge on lane1 -> ready high.
REQ-035 Credits 16, token edge lane0 -> credit stays 16, err_o=1 and remains 1 until rst.
REQ-036 Credits 5/5, accept plus lane0 token edge same cycle -> lane0 12, lane1 4; held-high token gives no second edge.
REQ-037 rst asserted during PH0 -> next cycle IDLE, io_valid_o=0, credits 16/16, sent_cnt_o=0.

Source files
------------

// File: rtl/link_upstream_nch_if.sv
// Core-to-lane upstream bundle: core word handshake, per-lane outputs and tokens, status.
// Pure wiring; adds no latency.
// Core side uses valid/ready handshaking, and lane-side flow control is credit tokens.
interface link_upstream_nch_if #(
  parameter int CHANNELS = 2,
  parameter int CH_WIDTH = 8,
  parameter int CREDITS  = 16
);
  localparam int CORE_W = 2 * CHANNELS * CH_WIDTH;
  localparam int CRW    = $clog2(CREDITS + 1);

  logic                         core_valid_i;
  logic [CORE_W-1:0]            core_data_i;
  logic                         core_ready_o;
  logic [CHANNELS-1:0]          io_valid_o;
  logic [CHANNELS*CH_WIDTH-1:0] io_data_o;
  logic [CHANNELS-1:0]          io_token_i;
  logic [CHANNELS*CRW-1:0]      credits_o;
  logic [7:0]                   sent_cnt_o;
  logic                         err_o;

  // The link block itself.
  modport slave (
    input  core_valid_i, core_data_i, io_token_i,
    output core_ready_o, io_valid_o, io_data_o, credits_o, sent_cnt_o, err_o
  );

  // The core and the far end of the lanes.
  modport master (
    output core_valid_i, core_data_i, io_token_i,
    input  core_ready_o, io_valid_o, io_data_o, credits_o, sent_cnt_o, err_o
  );
endinterface

// File: rtl/link_upstream_nch.sv
// Splits each core word into two lane phases and tracks credits for each lane, returned by token edges.
// Lanes show the low half one cycle after accept and the high half two cycles after accept; back-to-back accepts add no bubble.
// core_ready_o drops in PH0, during rst, and while any lane has no credit.
module link_upstream_nch #(
  parameter int CHANNELS    = 2,
  parameter int CH_WIDTH    = 8,
  parameter int CREDITS     = 16,
  parameter int TOKEN_DECIM = 8
) (
  input logic             clk,
  input logic             rst,
  link_upstream_nch_if.slave bus
);
  localparam int CORE_W = 2 * CHANNELS * CH_WIDTH;
  localparam int CRW    = $clog2(CREDITS + 1);
  localparam int LANE_W = CHANNELS * CH_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH0  = 2'd1;
  localparam logic [1:0] PH1  = 2'd2;

  // Credit arithmetic runs one bit wider, so a token on a full lane can be seen as an overflow.
  localparam logic [CRW:0]   DECIM_X = (CRW+1)'(TOKEN_DECIM);
  localparam logic [CRW:0]   CAP_X   = (CRW+1)'(CREDITS);
  localparam logic [CRW-1:0] CAP     = CRW'(CREDITS);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CORE_W-1:0]   hold;
  logic [CRW-1:0]      credit      [CHANNELS];
  logic [CRW-1:0]      credit_nxt  [CHANNELS];
  logic [CRW:0]        credit_sum  [CHANNELS];
  logic [CHANNELS-1:0] token_q;
  logic [CHANNELS-1:0] token_edge;
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] lane_ok;
  logic [7:0]          sent_cnt;
  logic                err;
  logic                ready;
  logic                accept;
  logic [CHANNELS-1:0] io_valid;
  logic [LANE_W-1:0]   io_data;
  logic [CHANNELS*CRW-1:0] credits_flat;

  // A lane may take another word only while it holds at least one credit.
  always_comb begin
    lane_ok = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      lane_ok[c] = (credit[c] != '0);
    end
  end

  // A new word can start only when the previous word's high half is on the lanes, or when no word is in flight.
  assign ready      = !rst && (state == IDLE || state == PH1) && (&lane_ok);
  assign accept     = bus.core_valid_i & ready;
  assign token_edge = bus.io_token_i & ~token_q;

  // Next credit for each lane. Saturate at CREDITS, and flag any token that would push a lane past CREDITS.
  always_comb begin
    ovf = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      credit_sum[c] = {1'b0, credit[c]}
                    + (token_edge[c] ? DECIM_X : '0)
                    - {{CRW{1'b0}}, accept};
      ovf[c]        = (credit_sum[c] > CAP_X);
      credit_nxt[c] = ovf[c] ? CAP : credit_sum[c][CRW-1:0];
    end
  end

  // Phase sequencing. PH1 goes straight to PH0 when the next word is accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? PH0 : IDLE;
      PH0:     state_nxt = PH1;
      PH1:     state_nxt = accept ? PH0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, held word, token history, credits and status. Reset wins over everything and drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= '0;
      token_q  <= '0;
      sent_cnt <= '0;
      err      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        credit[c] <= CAP;
      end
    end else begin
      state   <= state_nxt;
      token_q <= bus.io_token_i;
      if (accept) begin
        hold     <= bus.core_data_i;
        sent_cnt <= sent_cnt + 8'd1;
      end
      if (|ovf) begin
        err <= 1'b1;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        credit[c] <= credit_nxt[c];
      end
    end
  end

  // Lane outputs. The low half of the held word goes out in PH0, the high half in PH1, and all lanes are zero in IDLE.
  always_comb begin
    io_valid = '0;
    io_data  = '0;
    case (state)
      PH0: begin
        io_valid = '1;
        io_data  = hold[LANE_W-1:0];
      end
      PH1: begin
        io_valid = '1;
        io_data  = hold[CORE_W-1:LANE_W];
      end
      default: begin
        io_valid = '0;
        io_data  = '0;
      end
    endcase
  end

  // Pack the lane credits side by side, with lane c at [c*CRW +: CRW].
  always_comb begin
    credits_flat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      credits_flat[c*CRW +: CRW] = credit[c];
    end
  end

  assign bus.core_ready_o = ready;
  assign bus.io_valid_o   = io_valid;
  assign bus.io_data_o    = io_data;
  assign bus.credits_o    = credits_flat;
  assign bus.sent_cnt_o   = sent_cnt;
  assign bus.err_o        = err;
endmodule

// File: tb/tb_link_upstream_nch.sv
// Self-checking bench for link_upstream_nch at default parameters.
// A vector table covers the basic word path. Hand sequences cover credit starvation, tokens, saturation, counter wrap and reset.
// A scoreboard queue holds the lane halves expected for every accepted word.
module tb_link_upstream_nch;
  localparam int CH  = 2;
  localparam int CW  = 8;
  localparam int CR  = 16;
  localparam int TD  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_upstream_nch_if #(.CHANNELS(CH), .CH_WIDTH(CW), .CREDITS(CR)) bus ();

  link_upstream_nch #(.CHANNELS(CH), .CH_WIDTH(CW), .CREDITS(CR), .TOKEN_DECIM(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [1:0]  tok;
    logic        rdy;
    logic [1:0]  iov;
    logic [15:0] iod;
    logic [4:0]  c0;
    logic [4:0]  c1;
    logic [7:0]  sent;
    logic        err;
  } vec_t;

  vec_t        vecs [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;
  logic [15:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic chk_stat(input string t, input logic rdy, input logic [1:0] iov,
                          input logic [4:0] c0, input logic [4:0] c1,
                          input logic [7:0] sent, input logic err);
    chk({t, ".ready"}, 32'(bus.core_ready_o), 32'(rdy));
    chk({t, ".io_valid"}, 32'(bus.io_valid_o), 32'(iov));
    chk({t, ".credit0"}, 32'(bus.credits_o[4:0]), 32'(c0));
    chk({t, ".credit1"}, 32'(bus.credits_o[9:5]), 32'(c1));
    chk({t, ".sent_cnt"}, 32'(bus.sent_cnt_o), 32'(sent));
    chk({t, ".err"}, 32'(bus.err_o), 32'(err));
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Compare the lanes against the scoreboard and record any handshake, then move past the next rising edge.
  task automatic go_edge();
    if (bus.io_valid_o != '0) begin
      chk("io_valid_all", 32'(bus.io_valid_o), 32'h3);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: lane data %0h with nothing expected (cycle %0d)", bus.io_data_o, cyc_n);
      end else begin
        chk("io_data", 32'(bus.io_data_o), 32'(sb.pop_front()));
      end
    end else begin
      chk("idle_data", 32'(bus.io_data_o), 32'h0);
    end
    if (bus.core_valid_i && bus.core_ready_o) begin
      sb.push_back(bus.core_data_i[15:0]);
      sb.push_back(bus.core_data_i[31:16]);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic tick();
    at_neg();
    go_edge();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.core_valid_i = 1'b1;
    bus.io_token_i = 2'b00;
    at_neg();
    chk("rst_ready_low", 32'(bus.core_ready_o), 32'h0);
    go_edge();
    tick();
    rst = 1'b0;
    bus.core_valid_i = 1'b0;
    sb.delete();
  endtask

  task automatic do_accepts(input int cnt);
    int n;
    n = 0;
    for (int k = 0; k < 4*cnt + 8 && n < cnt; k++) begin
      bus.core_valid_i = 1'b1;
      bus.core_data_i = $urandom;
      at_neg();
      if (bus.core_ready_o) n++;
      go_edge();
    end
    bus.core_valid_i = 1'b0;
    chk("accepts_done", 32'(n), 32'(cnt));
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first;
    int last;

    // Basic path: A=44332211, then B and C accepted back to back at PH1.
    vecs[0] = '{1'b1, 32'h44332211, 2'b00, 1'b1, 2'b00, 16'h0000, 5'd16, 5'd16, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 32'hDDCCBBAA, 2'b00, 1'b0, 2'b11, 16'h2211, 5'd15, 5'd15, 8'd1, 1'b0};
    vecs[2] = '{1'b1, 32'hDDCCBBAA, 2'b00, 1'b1, 2'b11, 16'h4433, 5'd15, 5'd15, 8'd1, 1'b0};
    vecs[3] = '{1'b1, 32'h0F0E0D0C, 2'b00, 1'b0, 2'b11, 16'hBBAA, 5'd14, 5'd14, 8'd2, 1'b0};
    vecs[4] = '{1'b1, 32'h0F0E0D0C, 2'b00, 1'b1, 2'b11, 16'hDDCC, 5'd14, 5'd14, 8'd2, 1'b0};
    vecs[5] = '{1'b0, 32'h00000000, 2'b00, 1'b0, 2'b11, 16'h0D0C, 5'd13, 5'd13, 8'd3, 1'b0};
    vecs[6] = '{1'b0, 32'h00000000, 2'b00, 1'b1, 2'b11, 16'h0F0E, 5'd13, 5'd13, 8'd3, 1'b0};
    vecs[7] = '{1'b0, 32'h00000000, 2'b00, 1'b1, 2'b00, 16'h0000, 5'd13, 5'd13, 8'd3, 1'b0};

    bus.core_valid_i = 1'b0;
    bus.core_data_i = '0;
    bus.io_token_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    at_neg();
    chk_stat("reset", 1'b1, 2'b00, 5'd16, 5'd16, 8'd0, 1'b0);
    go_edge();

    for (int i = 0; i < 8; i++) begin
      bus.core_valid_i = vecs[i].v;
      bus.core_data_i = vecs[i].d;
      bus.io_token_i = vecs[i].tok;
      at_neg();
      chk_stat($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].iov, vecs[i].c0, vecs[i].c1,
               vecs[i].sent, vecs[i].err);
      chk($sformatf("vec%0d.io_data", i), 32'(bus.io_data_o), 32'(vecs[i].iod));
      go_edge();
    end
    bus.core_valid_i = 1'b0;

    // Sixteen back-to-back accepts drain both lanes to zero credit.
    do_reset();
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 60 && n < 16; k++) begin
      bus.core_valid_i = 1'b1;
      bus.core_data_i = {8'(n), 8'(n + 16), 8'(n + 32), 8'(n + 48)};
      at_neg();
      if (bus.core_ready_o) begin
        if (n == 0) first = cyc_n;
        last = cyc_n;
        n++;
      end
      go_edge();
    end
    chk("b2b_count", 32'(n), 32'd16);
    chk("b2b_span", 32'(last - first), 32'd30);
    at_neg();
    chk_stat("b2b_ph0", 1'b0, 2'b11, 5'd0, 5'd0, 8'd16, 1'b0);
    go_edge();
    at_neg();
    chk_stat("b2b_ph1", 1'b0, 2'b11, 5'd0, 5'd0, 8'd16, 1'b0);
    go_edge();
    at_neg();
    chk_stat("b2b_idle", 1'b0, 2'b00, 5'd0, 5'd0, 8'd16, 1'b0);
    go_edge();
    bus.core_valid_i = 1'b0;

    // Token on lane 0 only: still not ready. A lane 1 token then opens the core side.
    bus.io_token_i = 2'b01;
    tick();
    at_neg();
    chk_stat("tok_l0", 1'b0, 2'b00, 5'd8, 5'd0, 8'd16, 1'b0);
    go_edge();
    bus.io_token_i = 2'b11;
    tick();
    at_neg();
    chk_stat("tok_l1", 1'b1, 2'b00, 5'd8, 5'd8, 8'd16, 1'b0);
    go_edge();

    // Bring both lanes to 5, then accept and take a lane 0 token in the same cycle.
    bus.io_token_i = 2'b00;
    do_accepts(3);
    at_neg();
    chk_stat("at5", 1'b1, 2'b00, 5'd5, 5'd5, 8'd19, 1'b0);
    go_edge();
    bus.core_valid_i = 1'b1;
    bus.core_data_i = 32'hCAFEF00D;
    bus.io_token_i = 2'b01;
    at_neg();
    chk("both_ready", 32'(bus.core_ready_o), 32'h1);
    go_edge();
    bus.core_valid_i = 1'b0;
    at_neg();
    chk_stat("both_net", 1'b0, 2'b11, 5'd12, 5'd4, 8'd20, 1'b0);
    go_edge();
    tick();
    tick();
    at_neg();
    chk_stat("tok_held", 1'b1, 2'b00, 5'd12, 5'd4, 8'd20, 1'b0);
    go_edge();

    // Counter wrap: 257 accepts with tokens keeping credit flowing.
    do_reset();
    n = 0;
    for (int k = 0; k < 2000 && n < 257; k++) begin
      bus.core_valid_i = 1'b1;
      bus.core_data_i = $urandom;
      bus.io_token_i = ((k % 16) < 8) ? 2'b00 : 2'b11;
      at_neg();
      if (bus.core_ready_o) n++;
      go_edge();
    end
    bus.core_valid_i = 1'b0;
    bus.io_token_i = 2'b00;
    repeat (3) tick();
    at_neg();
    chk("wrap_count", 32'(n), 32'd257);
    chk("wrap_sent", 32'(bus.sent_cnt_o), 32'd1);
    go_edge();

    // A token on a full lane saturates it and sets err, which stays set until reset.
    do_reset();
    at_neg();
    chk("ovf_err_clear", 32'(bus.err_o), 32'h0);
    go_edge();
    bus.io_token_i = 2'b01;
    tick();
    at_neg();
    chk_stat("ovf", 1'b1, 2'b00, 5'd16, 5'd16, 8'd0, 1'b1);
    go_edge();
    bus.io_token_i = 2'b00;
    repeat (3) tick();
    at_neg();
    chk("ovf_sticky", 32'(bus.err_o), 32'h1);
    go_edge();

    // Reset during PH0 drops the word and returns the block to its reset state.
    do_reset();
    at_neg();
    chk("err_after_rst", 32'(bus.err_o), 32'h0);
    go_edge();
    bus.core_valid_i = 1'b1;
    bus.core_data_i = 32'h89ABCDEF;
    tick();
    rst = 1'b1;
    at_neg();
    chk("rst_ph0_valid", 32'(bus.io_valid_o), 32'h3);
    chk("rst_ph0_ready", 32'(bus.core_ready_o), 32'h0);
    go_edge();
    rst = 1'b0;
    bus.core_valid_i = 1'b0;
    sb.delete();
    at_neg();
    chk_stat("after_rst", 1'b1, 2'b00, 5'd16, 5'd16, 8'd0, 1'b0);
    go_edge();

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
